dmem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer in front of the single data memory (dmem).

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared types and constants for the data-memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Word accesses only; a nonzero byte offset is rejected when checking is on.
  function automatic logic addr_misaligned(input logic [1:0] lsb, input logic check_en);
    return check_en && (lsb != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if : requester ports (CPU, DMA) and dmem strobe bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata;

  logic          CS;
  logic          DM_W;
  logic          DM_R;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] dm_rdata;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata,
    output CS, DM_W, DM_R, addr, wdata,
    input  dm_rdata
  );

  // Requesters plus memory side
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata,
    input  CS, DM_W, DM_R, addr, wdata,
    output dm_rdata
  );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin picker with lock-owner override
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = 1'b0;
    if (lock_valid && req[lock_owner]) begin
      winner = lock_owner;
    end else if (req == 2'b11) begin
      winner = ~rr_last;
    end else begin
      // Single requester (value irrelevant when nobody requests)
      winner = req[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : CPU/DMA arbiter and sequencer in front of the data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW          = DMEM_AW,
  parameter int DW          = DMEM_DW,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_t        state_q;
  state_t        state_d;

  logic          rr_last_q;
  logic          lock_valid_q;
  logic          lock_owner_q;
  logic          port_q;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          winner;
  logic          any_req;
  logic          grant;
  logic          sel_we;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_access;
  logic          in_resp;
  logic          mem_cs;

  rr_arb2 u_arb (
    .req        ({bus.req1, bus.req0}),
    .rr_last    (rr_last_q),
    .lock_valid (lock_valid_q),
    .lock_owner (lock_owner_q),
    .winner     (winner),
    .any        (any_req)
  );

  always_comb begin
    sel_we    = (winner == PORT_DMA) ? bus.we1    : bus.we0;
    sel_lock  = (winner == PORT_DMA) ? bus.lock1  : bus.lock0;
    sel_addr  = (winner == PORT_DMA) ? bus.addr1  : bus.addr0;
    sel_wdata = (winner == PORT_DMA) ? bus.wdata1 : bus.wdata0;
  end

  // Next-state: a new request may be accepted while the previous one responds
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_last_q    <= winner;
        lock_valid_q <= sel_lock;
        lock_owner_q <= winner;
        port_q       <= winner;
        we_q         <= sel_we;
        err_q        <= addr_misaligned(sel_addr[1:0], ALIGN_CHECK);
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
      end else if (state_q != ST_ACCESS) begin
        // Arbitration slot with no requester: the lock holder has let go
        lock_valid_q <= 1'b0;
      end
      if (in_access && !err_q) begin
        rdata_q <= bus.dm_rdata;
      end
    end
  end

  always_comb begin
    in_access   = (state_q == ST_ACCESS);
    in_resp     = (state_q == ST_RESP);
    mem_cs      = in_access && !err_q;

    bus.gnt0    = grant && (winner == PORT_CPU);
    bus.gnt1    = grant && (winner == PORT_DMA);

    bus.CS      = mem_cs;
    bus.DM_W    = mem_cs && we_q;
    bus.DM_R    = mem_cs && !we_q;
    bus.addr    = addr_q;
    bus.wdata   = wdata_q;

    bus.rvalid0 = in_resp && (port_q == PORT_CPU);
    bus.rvalid1 = in_resp && (port_q == PORT_DMA);
    bus.err0    = in_resp && (port_q == PORT_CPU) && err_q;
    bus.err1    = in_resp && (port_q == PORT_DMA) && err_q;
    bus.rdata   = rdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a word-addressed dmem
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .ALIGN_CHECK(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Simple dmem: combinational read, write on posedge when selected
  logic [31:0] dmem_arr [0:255];
  assign bus.dm_rdata = dmem_arr[bus.addr[9:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) dmem_arr[i] <= '0;
    end else if (bus.CS && bus.DM_W) begin
      dmem_arr[bus.addr[9:2]] <= bus.wdata;
    end
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    check_val(tag, {31'b0, got}, {31'b0, exp});
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [0:255];
  int          age = -1;          // cycles since the in-flight grant; -1 none
  logic        m_rr_last  = 1'b1;
  logic        m_lock_v   = 1'b0;
  logic        m_lock_own = 1'b0;
  logic        c_port, c_we, c_mis;
  logic [31:0] c_addr, c_wdata, c_exp;
  int          gnt_log[$];
  logic        saw_b2b = 1'b0;

  function automatic logic pick(input logic r0, input logic r1, input logic lv,
                                input logic lo, input logic last);
    if (lv && (lo ? r1 : r0)) return lo;
    if (r0 && r1) return !last;
    return r1;
  endfunction

  initial begin
    logic exp_cs, can, anyr, w, lk;
    forever begin
      @(negedge clk);
      if (mem_clear) for (int i = 0; i < 256; i++) ref_mem[i] = '0;

      exp_cs = (age == 1) && !c_mis;
      check_bit("cs",   bus.CS,   exp_cs);
      check_bit("dm_w", bus.DM_W, exp_cs && c_we);
      check_bit("dm_r", bus.DM_R, exp_cs && !c_we);
      if (exp_cs) begin
        check_val("addr", bus.addr, c_addr);
        if (c_we) check_val("wdata", bus.wdata, c_wdata);
      end
      check_bit("rvalid0", bus.rvalid0, (age == 2) && !c_port);
      check_bit("rvalid1", bus.rvalid1, (age == 2) && c_port);
      check_bit("err0", bus.err0, (age == 2) && !c_port && c_mis);
      check_bit("err1", bus.err1, (age == 2) && c_port && c_mis);
      if ((age == 2) && !c_we && !c_mis) check_val("rdata", bus.rdata, c_exp);

      can  = (age < 0) || (age == 2);
      anyr = bus.req0 || bus.req1;
      w    = pick(bus.req0, bus.req1, m_lock_v, m_lock_own, m_rr_last);
      check_bit("gnt0", bus.gnt0, can && anyr && !w);
      check_bit("gnt1", bus.gnt1, can && anyr && w);
      if (bus.gnt0) gnt_log.push_back(0);
      if (bus.gnt1) gnt_log.push_back(1);
      if (bus.gnt0 && bus.rvalid0) saw_b2b = 1'b1;

      if (reset) begin
        age = -1; m_rr_last = 1'b1; m_lock_v = 1'b0; m_lock_own = 1'b0;
      end else if (can && anyr) begin
        c_port  = w;
        c_we    = w ? bus.we1 : bus.we0;
        c_addr  = w ? bus.addr1 : bus.addr0;
        c_wdata = w ? bus.wdata1 : bus.wdata0;
        lk      = w ? bus.lock1 : bus.lock0;
        c_mis   = (c_addr[1:0] != 2'b00);
        if (c_we && !c_mis) ref_mem[c_addr[9:2]] = c_wdata;
        c_exp      = ref_mem[c_addr[9:2]];
        m_rr_last  = w;
        m_lock_v   = lk;
        m_lock_own = w;
        age        = 1;
      end else begin
        if (can) m_lock_v = 1'b0;
        if (age == 2) age = -1;
        else if (age >= 0) age++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input logic r, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic lk);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = lk;
    end
  endtask

  // Returns at posedge+1 of the ACCESS cycle with the request dropped
  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic lk, output logic rv_at_gnt);
    logic got;
    got = 1'b0;
    rv_at_gnt = 1'b0;
    @(posedge clk); #1;
    set_port(p, 1'b1, we, a, d, lk);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.gnt0 : bus.gnt1) begin
        got = 1'b1;
        rv_at_gnt = (p == 0) ? bus.rvalid0 : bus.rvalid1;
      end
    end
    check_bit("gnt_seen", got, 1'b1);
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_rv(input int p, output logic [31:0] data, output logic e, output int lat);
    logic got;
    got = 1'b0; data = '0; e = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.rvalid0 : bus.rvalid1) begin
        got  = 1'b1;
        data = bus.rdata;
        e    = (p == 0) ? bus.err0 : bus.err1;
        lat  = i;
      end
    end
    check_bit("rv_seen", got, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        rv, e, g0, g1, r, got;
    logic [31:0] d, a;
    int          lat, base;

    set_port(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_port(1, 1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; mem_clear = 1'b0;
    @(negedge clk);
    check_val("rst_addr",  bus.addr,  32'h0);
    check_val("rst_wdata", bus.wdata, 32'h0);
    check_val("rst_rdata", bus.rdata, 32'h0);

    // 1: single write then read back
    issue(0, 1'b1, 32'h0, 32'h2, 1'b0, rv);
    wait_rv(0, d, e, lat);
    check_val("t1_wr_lat", 32'(lat), 32'd2);
    issue(0, 1'b0, 32'h0, 32'h0, 1'b0, rv);
    wait_rv(0, d, e, lat);
    check_val("t1_rdata", d, 32'h2);

    // 2: both requesting straight out of reset alternate, port 0 first
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    set_port(1, 1'b1, 1'b0, 32'h4, '0, 1'b0);
    gnt_log.delete();
    for (int i = 0; i < 40 && gnt_log.size() < 5; i++) @(negedge clk);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_port(1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    check_bit("t2_len", gnt_log.size() >= 4, 1'b1);
    if (gnt_log.size() >= 4)
      for (int i = 0; i < 4; i++) check_val("t2_order", 32'(gnt_log[i]), 32'(i % 2));

    // 3: DMA locked burst holds off a waiting CPU request
    gnt_log.delete();
    issue(1, 1'b1, 32'h10, 32'hA0, 1'b1, rv);
    set_port(0, 1'b1, 1'b0, 32'h40, '0, 1'b0);
    issue(1, 1'b1, 32'h14, 32'hA1, 1'b1, rv);
    issue(1, 1'b1, 32'h18, 32'hA2, 1'b0, rv);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.gnt0;
    end
    check_bit("t3_gnt0", got, 1'b1);
    @(posedge clk); #1 set_port(0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    check_bit("t3_len", gnt_log.size() >= 4, 1'b1);
    if (gnt_log.size() >= 4) begin
      check_val("t3_g0", 32'(gnt_log[0]), 32'd1);
      check_val("t3_g1", 32'(gnt_log[1]), 32'd1);
      check_val("t3_g2", 32'(gnt_log[2]), 32'd1);
      check_val("t3_g3", 32'(gnt_log[3]), 32'd0);
    end

    // 4: misaligned access errors and leaves memory untouched
    issue(0, 1'b1, 32'h4, 32'h1234_5678, 1'b0, rv);
    wait_rv(0, d, e, lat);
    issue(0, 1'b1, 32'h6, 32'hDEAD_BEEF, 1'b0, rv);
    wait_rv(0, d, e, lat);
    check_bit("t4_err", e, 1'b1);
    check_val("t4_lat", 32'(lat), 32'd2);
    issue(0, 1'b0, 32'h4, '0, 1'b0, rv);
    wait_rv(0, d, e, lat);
    check_bit("t4_noerr", e, 1'b0);
    check_val("t4_rdata", d, 32'h1234_5678);

    // 5: reset during the ACCESS cycle of a write
    issue(0, 1'b1, 32'h20, 32'hAB, 1'b0, rv);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_bit("t5_rv0", bus.rvalid0, 1'b0);
    check_bit("t5_cs", bus.CS, 1'b0);
    check_val("t5_addr", bus.addr, 32'h0);
    check_val("t5_wdata", bus.wdata, 32'h0);
    check_val("t5_rdata", bus.rdata, 32'h0);
    issue(0, 1'b0, 32'h20, '0, 1'b0, rv);
    wait_rv(0, d, e, lat);
    check_val("t5_readback", d, 32'hAB);

    // 6: back-to-back from the same port
    issue(0, 1'b1, 32'h30, 32'h55, 1'b0, rv);
    issue(0, 1'b0, 32'h30, '0, 1'b0, rv);
    check_bit("t6_gnt_with_rv", rv, 1'b1);
    wait_rv(0, d, e, lat);
    check_val("t6_rdata", d, 32'h55);
    check_bit("t6_b2b_seen", saw_b2b, 1'b1);

    // Random traffic from both ports
    base = gnt_log.size();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? bus.req0 : bus.req1;
        if (r && ((p == 0) ? g0 : g1)) begin
          r = 1'b0;
          set_port(p, 1'b0, 1'b0, '0, '0, 1'b0);
        end else if (r && ($urandom_range(0, 15) == 0)) begin
          r = 1'b0;
          set_port(p, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        if (!r && ($urandom_range(0, 2) == 0)) begin
          a = 32'($urandom_range(0, 15)) << 2;
          if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom,
                   (p == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0));
        end
      end
    end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_port(1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (5) @(posedge clk);
    check_bit("rand_activity", (gnt_log.size() - base) > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
